// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mips_mem_pkg;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_MAX_DSTREAK = 4;

    typedef logic [DEF_AW-1:0] addr_t;
    typedef logic [DEF_DW-1:0] word_t;

    // Who receives the response one cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Registered response tag captured at grant time.
    typedef struct packed {
        owner_e owner;
        logic   err;   // misaligned D access, no memory effect
        logic   we;    // D write, response is a bare ack
    } resp_t;

    // Bits needed to count 0..max_streak; never less than one bit.
    function automatic int streak_width(input int max_streak);
        int w;
        w = $clog2(max_streak + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mips_mem_arb_prio.sv
// Priority picker: data wins conflicts until it has won MAX_DSTREAK in a row,
// then fetch gets one turn. Purely combinational.
module mips_mem_arb_prio
    import mips_mem_pkg::*;
#(
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int SW          = streak_width(MAX_DSTREAK)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] streak,
    output logic          if_gnt,
    output logic          d_gnt,
    output logic [SW-1:0] streak_next
);

    // Grant selection and streak update; only a D-over-IF win keeps counting.
    always_comb begin
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        streak_next = '0;
        if (if_req && d_req) begin
            if (streak >= SW'(MAX_DSTREAK)) begin
                if_gnt = 1'b1;
            end else begin
                d_gnt       = 1'b1;
                streak_next = streak + SW'(1);
            end
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter between instruction fetch and load/store for one single-ported
// memory. One grant per cycle; the response is routed back to its owner
// exactly one cycle later using a registered owner tag.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int SW = streak_width(MAX_DSTREAK);

    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;
    logic          pick_if;
    logic          pick_d;
    logic          d_aligned;
    resp_t         resp_reg;
    resp_t         resp_next;

    mips_mem_arb_prio #(
        .MAX_DSTREAK (MAX_DSTREAK),
        .SW          (SW)
    ) u_prio (
        .if_req      (if_req_i),
        .d_req       (d_req_i),
        .streak      (streak_reg),
        .if_gnt      (pick_if),
        .d_gnt       (pick_d),
        .streak_next (streak_next)
    );

    // Grants are masked while reset is held so every output reads 0 at once.
    assign if_gnt_o  = pick_if & nrst_i;
    assign d_gnt_o   = pick_d & nrst_i;
    assign d_aligned = (d_addr_i[1:0] == 2'b00);

    // Memory port mux: the granted requester drives address, enable and data.
    always_comb begin
        mem_req_o   = if_gnt_o | (d_gnt_o & d_aligned);
        mem_we_o    = d_gnt_o & d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_wdata_o = d_wdata_i;
            end
        end
    end

    // Response tag for the grant issued this cycle.
    always_comb begin
        resp_next = '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
        if (if_gnt_o) begin
            resp_next.owner = OWN_IF;
        end else if (d_gnt_o) begin
            resp_next.owner = OWN_D;
            resp_next.err   = ~d_aligned;
            resp_next.we    = d_we_i;
        end
    end

    // Streak counter and response tag; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            streak_reg <= '0;
            resp_reg   <= '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
        end else begin
            streak_reg <= streak_next;
            resp_reg   <= resp_next;
        end
    end

    // Response routing; the non-owner sees zero data.
    always_comb begin
        if_rvalid_o = (resp_reg.owner == OWN_IF);
        d_rvalid_o  = (resp_reg.owner == OWN_D);
        d_err_o     = d_rvalid_o & resp_reg.err;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = (d_rvalid_o && !resp_reg.err && !resp_reg.we) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed plan steps followed by randomized
// traffic, checked against a transaction-level model and a shadow memory.
module tb_mips_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [256];
    int          m_dwins;     // consecutive conflict wins by D
    int          p_kind;      // 0 none, 1 IF, 2 D: expected response next cycle
    logic [31:0] p_data;
    logic        p_err;

    logic [31:0] mem_arr [256];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(MAXS)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h2402000A + 32'(i) * 32'h01000101;
    endfunction

    // Memory macro: registered read, write on strobe.
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_req) begin
                if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
                else        mem_rdata <= mem_arr[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dwins = 0;
        p_kind  = 0;
        p_data  = '0;
        p_err   = 1'b0;
    endtask

    // One clock cycle: apply requests, check grants/memory drive and the
    // response owed from the previous grant, then advance the model.
    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dw,
                         output logic gi, output logic gd,
                         output logic obs_if, output logic obs_d);
        logic e_d;
        logic e_if;
        logic e_err;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dw;
        @(negedge clk);
        obs_if = if_gnt;
        obs_d  = d_gnt;
        e_d   = dr && !(ir && m_dwins >= MAXS);
        e_if  = ir && !e_d;
        e_err = e_d && (da[1:0] != 2'b00);
        chk("if_gnt", 32'(if_gnt), 32'(e_if));
        chk("d_gnt", 32'(d_gnt), 32'(e_d));
        chk("mem_req", 32'(mem_req), 32'(e_if || (e_d && !e_err)));
        if (e_if || e_d) begin
            chk("mem_addr", mem_addr, e_if ? ia : da);
            chk("mem_we", 32'(mem_we), 32'(e_d && dwe));
            chk("mem_wdata", mem_wdata, (e_d && dwe) ? dw : 32'h0);
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(p_kind == 1));
        chk("if_rdata", if_rdata, (p_kind == 1) ? p_data : 32'h0);
        chk("d_rvalid", 32'(d_rvalid), 32'(p_kind == 2));
        chk("d_err", 32'(d_err), 32'(p_kind == 2 && p_err));
        chk("d_rdata", d_rdata, (p_kind == 2) ? p_data : 32'h0);

        if (ir && dr) m_dwins = e_d ? m_dwins + 1 : 0;
        else          m_dwins = 0;

        p_kind = 0;
        p_data = '0;
        p_err  = 1'b0;
        if (e_if) begin
            p_kind = 1;
            p_data = ref_mem[ia[9:2]];
            $display("[%0t] IF  rd  addr=%h data=%h", $time, ia, p_data);
        end else if (e_d) begin
            p_kind = 2;
            p_err  = e_err;
            if (!e_err) begin
                if (dwe) ref_mem[da[9:2]] = dw;
                else     p_data = ref_mem[da[9:2]];
            end
            $display("[%0t] D   %s addr=%h wdata=%h rdata=%h err=%0d", $time,
                     dwe ? "wr" : "rd", da, dw, p_data, e_err);
        end
        gi = e_if;
        gd = e_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        gi, gd, oi, od;
        logic [9:0]  pat;
        logic [4:0]  pat5;
        logic        r_ir, r_dr, r_dwe;
        logic [31:0] r_ia, r_da, r_dw;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        nrst = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        nrst = 1'b1;

        // 1: single IF fetch of a known instruction
        cycle(1, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);
        chk("t1_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("t1_if_rdata", if_rdata, 32'h2402000A);
        chk("t1_d_rvalid", 32'(d_rvalid), 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // 2: write then immediate read-back of the same word
        cycle(0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF, gi, gd, oi, od);
        chk("t2_wr_ack", 32'(d_rvalid), 32'h1);
        chk("t2_wr_rdata", d_rdata, 32'h0);
        cycle(0, 32'h0, 1, 0, 32'h10, 32'h0, gi, gd, oi, od);
        chk("t2_rd_data", d_rdata, 32'hDEADBEEF);
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // 3: sustained conflict, D wins four times then IF once
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h20, 1, 0, 32'h40, 32'h0, gi, gd, oi, od);
            pat[9 - i] = oi;
        end
        chk("t3_pattern", 32'(pat), 32'(10'b0000100001));
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // 4: misaligned data read
        cycle(0, 32'h0, 1, 0, 32'h13, 32'h0, gi, gd, oi, od);
        chk("t4_rvalid", 32'(d_rvalid), 32'h1);
        chk("t4_err", 32'(d_err), 32'h1);
        chk("t4_rdata", d_rdata, 32'h0);
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // 5: reset right after an IF grant drops its response
        cycle(1, 32'h8, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);
        nrst = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h12345678;
        #1;
        chk("t5_if_gnt", 32'(if_gnt), 32'h0);
        chk("t5_d_gnt", 32'(d_gnt), 32'h0);
        chk("t5_mem_req", 32'(mem_req), 32'h0);
        chk("t5_mem_we", 32'(mem_we), 32'h0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_mem_wdata", mem_wdata, 32'h0);
        chk("t5_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("t5_if_rdata", if_rdata, 32'h0);
        chk("t5_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("t5_d_rdata", d_rdata, 32'h0);
        chk("t5_d_err", 32'(d_err), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);
        pat5 = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'h24, 1, 0, 32'h44, 32'h0, gi, gd, oi, od);
            pat5[4 - i] = oi;
        end
        chk("t5_streak_pattern", 32'(pat5), 32'(5'b00001));
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // 6: back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'(i * 4), 0, 0, 32'h0, 32'h0, gi, gd, oi, od);
            chk("t6_gnt", 32'(oi), 32'h1);
            chk("t6_rvalid", 32'(if_rvalid), 32'h1);
            chk("t6_rdata", if_rdata, ref_mem[i]);
        end
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        // Randomized traffic; each requester holds its request until granted
        r_ir = 0; r_dr = 0; r_dwe = 0; r_ia = 0; r_da = 0; r_dw = 0;
        for (int n = 0; n < 400; n++) begin
            if (!r_ir) begin
                r_ir = ($urandom_range(0, 3) != 0);
                r_ia = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!r_dr) begin
                r_dr  = ($urandom_range(0, 3) != 0);
                r_dwe = ($urandom_range(0, 2) == 0);
                r_da  = {22'h0, 8'($urandom_range(0, 15)),
                         ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                r_dw  = $urandom;
            end
            cycle(r_ir, r_ia, r_dr, r_dwe, r_da, r_dw, gi, gd, oi, od);
            if (gi) r_ir = 0;
            if (gd) r_dr = 0;
        end
        cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, gi, gd, oi, od);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
